// File: rtl/ext_div8.sv
// rtl/ext_div8.sv - multicycle unsigned 8-bit restoring divider on the CPU ext port
// Borrows the shared ALU for each subtract step and for returning the answer.
module ext_div8 #(
  parameter bit RESULT_SEL = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] a_bi,
  input  logic [7:0] b_bi,
  output logic       done,
  input  logic [7:0] alu_res,
  output logic       alu_mode,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_cnt;
  logic [7:0]  r_q;
  logic [7:0]  r_r;
  logic [7:0]  r_b;
  logic [8:0]  w_t;
  logic        w_ge;

  // When w_ge is set, t - b < b, so the 8-bit ALU difference is exact.
  assign w_t  = {r_r, r_q[7]};
  assign w_ge = (w_t >= {1'b0, r_b});

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    done        = 1'b0;
    alu_a       = 8'd0;
    alu_b       = 8'd0;
    alu_mode    = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_state_nxt = ST_ITER;
        end
      end
      ST_ITER: begin
        alu_a    = w_t[7:0];
        alu_b    = r_b;
        alu_mode = 1'b0;
        if (!start_i) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == 3'd7) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done        = 1'b1;
        alu_a       = RESULT_SEL ? r_r : r_q;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // alu_res only feeds the partial remainder register, never an output.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= 3'd0;
      r_q   <= 8'd0;
      r_r   <= 8'd0;
      r_b   <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_q   <= a_bi;
            r_b   <= b_bi;
            r_r   <= 8'd0;
            r_cnt <= 3'd0;
          end
        end
        ST_ITER: begin
          if (start_i) begin
            r_r   <= w_ge ? alu_res : w_t[7:0];
            r_q   <= {r_q[6:0], w_ge};
            r_cnt <= r_cnt + 3'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ext_div8.sv
// tb/tb_ext_div8.sv - self-checking bench for ext_div8 (quotient and remainder instances)
// Scoreboard of expected answers popped whenever done is seen.
module tb_ext_div8;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic [7:0] a_bi;
  logic [7:0] b_bi;
  logic       done0, done1;
  logic       mode0, mode1;
  logic [7:0] alu_a0, alu_a1, alu_b0, alu_b1;
  logic [7:0] res0, res1;

  always #5 clk = ~clk;

  assign res0 = mode0 ? (alu_a0 + alu_b0) : (alu_a0 - alu_b0);
  assign res1 = mode1 ? (alu_a1 + alu_b1) : (alu_a1 - alu_b1);

  ext_div8 #(.RESULT_SEL(1'b0)) u_quo (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .a_bi(a_bi), .b_bi(b_bi),
    .done(done0), .alu_res(res0), .alu_mode(mode0), .alu_a(alu_a0), .alu_b(alu_b0)
  );

  ext_div8 #(.RESULT_SEL(1'b1)) u_rem (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .a_bi(a_bi), .b_bi(b_bi),
    .done(done1), .alu_res(res1), .alu_mode(mode1), .alu_a(alu_a1), .alu_b(alu_b1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    int         c0;
  } exp_t;

  vec_t tbl[10];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_i && (done0 || done1)) begin
      exp_t e;
      chk("done_lockstep", int'(done1), int'(done0));
      chk("no_double_done", int'(prev_done), 0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("quotient", int'(alu_a0), int'(e.q));
        chk("remainder", int'(alu_a1), int'(e.r));
        chk("alu_res_q", int'(res0), int'(e.q));
        chk("done_alu_b", int'(alu_b0), 0);
        chk("done_alu_mode", int'(mode0), 1);
        chk("latency", cyc - e.c0, 9);
      end
    end
    prev_done = done0;
  end

  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] q, input logic [7:0] r, input bit keep);
    start_i = 1'b1;
    a_bi    = a;
    b_bi    = b;
    sb.push_back('{q, r, cyc});
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) begin
        a_bi = 8'($urandom);
        b_bi = 8'($urandom);
      end
      if (k <= 8) begin
        chk("iter_done", int'(done0), 0);
        chk("iter_mode", int'(mode0), 0);
        chk("iter_alu_b", int'(alu_b0), int'(b));
      end else begin
        chk("done_at_9", int'(done0), 1);
      end
    end
    if (!keep) start_i = 1'b0;
    @(negedge clk);
    chk("idle_after_done", int'(done0), 0);
    chk("idle_mode", int'(mode0), 1);
  endtask

  initial begin
    logic [7:0] ra, rb, rq, rr;

    tbl[0] = '{8'd200, 8'd7,   8'd28,  8'd4};
    tbl[1] = '{8'd255, 8'd255, 8'd1,   8'd0};
    tbl[2] = '{8'h5A,  8'd0,   8'hFF,  8'h5A};
    tbl[3] = '{8'd3,   8'd10,  8'd0,   8'd3};
    tbl[4] = '{8'd255, 8'd1,   8'd255, 8'd0};
    tbl[5] = '{8'd0,   8'd0,   8'hFF,  8'd0};
    tbl[6] = '{8'd0,   8'd5,   8'd0,   8'd0};
    tbl[7] = '{8'd128, 8'd2,   8'd64,  8'd0};
    tbl[8] = '{8'd254, 8'd255, 8'd0,   8'd254};
    tbl[9] = '{8'd129, 8'd128, 8'd1,   8'd1};

    rst_i   = 1'b1;
    start_i = 1'b0;
    a_bi    = 8'd0;
    b_bi    = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_done", int'(done0), 0);
    chk("rst_alu_a", int'(alu_a0), 0);
    chk("rst_alu_b", int'(alu_b0), 0);
    chk("rst_mode", int'(mode0), 1);
    chk("rst_alu_a_rem", int'(alu_a1), 0);
    rst_i = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, 1'b0);
    end

    do_op(8'd100, 8'd9, 8'd11, 8'd1, 1'b1);
    do_op(8'd17, 8'd17, 8'd1, 8'd0, 1'b0);

    start_i = 1'b1;
    a_bi    = 8'd50;
    b_bi    = 8'd3;
    for (int k = 1; k <= 4; k++) @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    chk("abort_done", int'(done0), 0);
    chk("abort_alu_a", int'(alu_a0), 0);
    chk("abort_mode", int'(mode0), 1);
    repeat (12) @(negedge clk);

    start_i = 1'b1;
    a_bi    = 8'd200;
    b_bi    = 8'd7;
    for (int k = 1; k <= 6; k++) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    chk("midrst_done", int'(done0), 0);
    chk("midrst_alu_a", int'(alu_a0), 0);
    chk("midrst_alu_b", int'(alu_b0), 0);
    chk("midrst_mode", int'(mode0), 1);
    rst_i   = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
    do_op(8'd200, 8'd7, 8'd28, 8'd4, 1'b0);

    for (int i = 0; i < 150; i++) begin
      ra = 8'($urandom);
      rb = (i % 5 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      rq = (rb == 8'd0) ? 8'hFF : ra / rb;
      rr = (rb == 8'd0) ? ra : ra % rb;
      do_op(ra, rb, rq, rr, 1'($urandom_range(0, 1)));
    end

    start_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
